mul_seq: RTL

Sequential 8×8 unsigned shift-and-add multiplier with a start/done handshake. It is the forward-direction counterpart of the iterative reciprocal unit. It takes an operand pair (x, y), for example a reciprocal estimate and its source value, and returns the full 16-bit product so the pair can be checked or rescaled. It sits beside the reciprocal unit on the same clock and uses the same single-pulse start convention.

---
 rtl/mul_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq : sequential unsigned shift-and-add multiplier (WIDTH x WIDTH)
//
// Returns the full 2*WIDTH-bit product of an operand pair using a single-pulse
// start / one-cycle done handshake. It shares the clock and start convention
// of the iterative reciprocal unit it sits beside.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        synchronous active-low reset
//   start  in   1        request; accepted in IDLE or DONE only
//   x      in   WIDTH    multiplicand, sampled on the accepting edge
//   y      in   WIDTH    multiplier,   sampled on the accepting edge
//   p      out  2*WIDTH  product; updated only when done rises (or reset)
//   busy   out  1        high while iterating
//   done   out  1        one-cycle pulse, p has just been updated
//
// Build option
//   MUL_SEQ_EARLY_EXIT_EN : when defined, iteration stops as soon as the
//   shifted multiplier is zero (minimum one iteration). Product is unchanged.
//
// State | Meaning
// IDLE  | waiting for start
// RUN   | one shift-and-add iteration per clock
// DONE  | p valid, done high for this one cycle; start may be accepted here
// -----------------------------------------------------------------------------
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;

  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [2*WIDTH-1:0] w_p_nxt;

  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_last;

  // Datapath for one RUN iteration; acc cannot overflow 2*WIDTH bits.
  assign w_acc_step   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_cnt_inc    = r_cnt + CW'(1);

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // Remaining multiplier bits all zero means no further additions can occur.
  assign w_last = (w_mplier_shr == '0) || (w_cnt_inc == CW'(WIDTH));
`else
  assign w_last = (w_cnt_inc == CW'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_p      <= w_p_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_p_nxt      = r_p;

    unique case (r_state)
      IDLE, DONE: begin
        // DONE accepts start just like IDLE so back-to-back ops lose no cycle.
        if (start) begin
          w_mcand_nxt  = {{WIDTH{1'b0}}, x};
          w_mplier_nxt = y;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = RUN;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      RUN: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_shr;
        w_cnt_nxt    = w_cnt_inc;
        if (w_last) begin
          w_p_nxt     = w_acc_step;
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign p    = r_p;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule
